// File: rtl/gpi_debounce.sv
// Input conditioning for the GPI block: two-flop synchroniser, shared tick prescaler,
// per-input debounce counters, edge-qualified interrupt with IE/IP/EDGE CSRs.
// Optional macro GPI_DEBOUNCE_BOTH_EDGES_EN adds a BOTH register at BASE_ADDR+3.
module gpi_debounce #(
    parameter logic [4:0]  BASE_ADDR      = 5'b0,
    parameter int unsigned NUM_GPIOS      = 8,
    parameter int unsigned PRESCALE       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           csr_a,
    input  logic [7:0]           csr_di,
    input  logic                 csr_we,
    output logic [7:0]           csr_do,
    input  logic [NUM_GPIOS-1:0] in,
    output logic [NUM_GPIOS-1:0] out,
    output logic                 irq
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

    localparam logic [4:0] A_IE   = BASE_ADDR;
    localparam logic [4:0] A_IP   = BASE_ADDR + 5'd1;
    localparam logic [4:0] A_EDGE = BASE_ADDR + 5'd2;
    localparam logic [4:0] A_RSV  = BASE_ADDR + 5'd3;

    logic [NUM_GPIOS-1:0] sync1_q, sync1_d;
    logic [NUM_GPIOS-1:0] sync2_q, sync2_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [CW-1:0]        cnt_q [NUM_GPIOS];
    logic [CW-1:0]        cnt_d [NUM_GPIOS];
    logic [NUM_GPIOS-1:0] out_q, out_d;
    logic [NUM_GPIOS-1:0] ie_q, ie_d;
    logic [NUM_GPIOS-1:0] ip_q, ip_d;
    logic [NUM_GPIOS-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_GPIOS-1:0] change, set_ip, w1c;
    logic                 tick;
`ifdef GPI_DEBOUNCE_BOTH_EDGES_EN
    logic [NUM_GPIOS-1:0] both_q, both_d;
`endif

    assign tick = (pre_q == PRE_MAX);

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        pre_d   = tick ? '0 : pre_q + 1'b1;
        out_d   = out_q;
        for (int i = 0; i < int'(NUM_GPIOS); i++) begin
            cnt_d[i] = cnt_q[i];
            // Any cycle where the synchronised level agrees with out restarts the count.
            if (sync2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_MAX) begin
                    out_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edges are qualified with the register values before this cycle's CSR write.
    always_comb begin
        change = out_d ^ out_q;
        set_ip = (change & out_d & ~edge_sel_q) | (change & ~out_d & edge_sel_q);
`ifdef GPI_DEBOUNCE_BOTH_EDGES_EN
        set_ip = set_ip | (change & both_q);
`endif
        w1c        = (csr_we && csr_a == A_IP) ? csr_di[NUM_GPIOS-1:0] : '0;
        ie_d       = (csr_we && csr_a == A_IE) ? csr_di[NUM_GPIOS-1:0] : ie_q;
        edge_sel_d = (csr_we && csr_a == A_EDGE) ? csr_di[NUM_GPIOS-1:0] : edge_sel_q;
        ip_d       = (ip_q & ~w1c) | set_ip;
`ifdef GPI_DEBOUNCE_BOTH_EDGES_EN
        both_d     = (csr_we && csr_a == A_RSV) ? csr_di[NUM_GPIOS-1:0] : both_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            pre_q      <= '0;
            out_q      <= '0;
            ie_q       <= '0;
            ip_q       <= '0;
            edge_sel_q <= '0;
            for (int i = 0; i < int'(NUM_GPIOS); i++) cnt_q[i] <= '0;
`ifdef GPI_DEBOUNCE_BOTH_EDGES_EN
            both_q     <= '0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            pre_q      <= pre_d;
            out_q      <= out_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            edge_sel_q <= edge_sel_d;
            for (int i = 0; i < int'(NUM_GPIOS); i++) cnt_q[i] <= cnt_d[i];
`ifdef GPI_DEBOUNCE_BOTH_EDGES_EN
            both_q     <= both_d;
`endif
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (csr_a == A_IE)        csr_do = 8'(ie_q);
        else if (csr_a == A_IP)   csr_do = 8'(ip_q);
        else if (csr_a == A_EDGE) csr_do = 8'(edge_sel_q);
`ifdef GPI_DEBOUNCE_BOTH_EDGES_EN
        else if (csr_a == A_RSV)  csr_do = 8'(both_q);
`endif
    end

    assign out = out_q;
    assign irq = |(ip_q & ie_q);

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed bench for gpi_debounce: main instance at PRESCALE=1, second at PRESCALE=10.
// Expected values are queued when stimulus is driven and popped at each check.
module tb_gpi_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic [7:0] in;
    logic [7:0] out;
    logic       irq;

    logic       rst10;
    logic [4:0] csr_a10;
    logic [7:0] csr_di10;
    logic       csr_we10;
    logic [7:0] csr_do10;
    logic [7:0] in10;
    logic [7:0] out10;
    logic       irq10;

    logic [7:0] exp_q [$];
    int checks   = 0;
    int failures = 0;
    int count;
    logic [7:0] rd;

    always #5 clk = ~clk;

    gpi_debounce #(.BASE_ADDR(5'd0), .NUM_GPIOS(8), .PRESCALE(1), .DEBOUNCE_TICKS(4)) dut (
        .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .in(in), .out(out), .irq(irq)
    );

    gpi_debounce #(.BASE_ADDR(5'd0), .NUM_GPIOS(8), .PRESCALE(10), .DEBOUNCE_TICKS(4)) dut10 (
        .clk(clk), .rst(rst10), .csr_a(csr_a10), .csr_di(csr_di10), .csr_we(csr_we10),
        .csr_do(csr_do10), .in(in10), .out(out10), .irq(irq10)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%02h expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%02h expected=%02h", tag, obs, e);
            end
        end
    endtask

    task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        step(1);
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [4:0] a, output logic [7:0] d);
        csr_a = a;
        #1;
        d = csr_do;
    endtask

    initial begin
        rst = 1'b1; in = 8'hFF; csr_a = 5'd0; csr_di = 8'h00; csr_we = 1'b0;
        rst10 = 1'b1; in10 = 8'h00; csr_a10 = 5'd1; csr_di10 = 8'h00; csr_we10 = 1'b0;
        step(3);

        // Reset state
        expect_push(8'h00); check_pop("reset_out", out);
        expect_push(8'h00); check_pop("reset_irq", {7'b0, irq});
        csr_read(5'd1, rd); expect_push(8'h00); check_pop("reset_ip", rd);

        // Inputs high across reset release: full latency, rising sets IP
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            expect_push(8'h00); check_pop("release_out_low", out);
        end
        step(1);
        expect_push(8'hFF); check_pop("release_out_high", out);
        csr_read(5'd1, rd); expect_push(8'hFF); check_pop("release_ip", rd);
        expect_push(8'h00); check_pop("release_irq_masked", {7'b0, irq});

        csr_write(5'd1, 8'hFF);
        csr_read(5'd1, rd); expect_push(8'h00); check_pop("w1c_all", rd);
        in = 8'h00;
        step(8);
        expect_push(8'h00); check_pop("fall_out", out);
        csr_read(5'd1, rd); expect_push(8'h00); check_pop("fall_no_ip", rd);

        // 3-cycle glitch on in[3]
        in = 8'h08;
        step(3);
        in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step(1);
            expect_push(8'h00); check_pop("glitch_out", out);
        end
        csr_read(5'd1, rd); expect_push(8'h00); check_pop("glitch_ip", rd);

        // 6-cycle pulse with IE[3]
        csr_write(5'd0, 8'h08);
        in = 8'h08;
        step(5);
        expect_push(8'h00); check_pop("pulse_out_pre", out);
        expect_push(8'h00); check_pop("pulse_irq_pre", {7'b0, irq});
        step(1);
        expect_push(8'h08); check_pop("pulse_out", out);
        expect_push(8'h01); check_pop("pulse_irq", {7'b0, irq});
        in = 8'h00;
        step(8);
        expect_push(8'h00); check_pop("pulse_out_fall", out);
        expect_push(8'h01); check_pop("pulse_irq_held", {7'b0, irq});
        csr_write(5'd0, 8'h00);
        expect_push(8'h00); check_pop("ie_mask_irq", {7'b0, irq});
        csr_read(5'd1, rd); expect_push(8'h08); check_pop("ie_mask_ip_kept", rd);
        csr_write(5'd1, 8'hFF);

        // Falling-edge select on in[0]
        csr_write(5'd2, 8'h01);
        csr_write(5'd0, 8'h01);
        csr_read(5'd2, rd); expect_push(8'h01); check_pop("edge_rd", rd);
        csr_read(5'd0, rd); expect_push(8'h01); check_pop("ie_rd", rd);
        in = 8'h01;
        step(8);
        expect_push(8'h01); check_pop("edge_out_rise", out);
        csr_read(5'd1, rd); expect_push(8'h00); check_pop("edge_rise_no_ip", rd);
        expect_push(8'h00); check_pop("edge_rise_irq", {7'b0, irq});
        in = 8'h00;
        step(5);
        csr_read(5'd1, rd); expect_push(8'h00); check_pop("edge_fall_pre_ip", rd);
        step(1);
        expect_push(8'h00); check_pop("edge_out_fall", out);
        csr_read(5'd1, rd); expect_push(8'h01); check_pop("edge_fall_ip", rd);
        expect_push(8'h01); check_pop("edge_fall_irq", {7'b0, irq});
        csr_write(5'd1, 8'h01);
        csr_read(5'd1, rd); expect_push(8'h00); check_pop("w1c_ip0", rd);
        expect_push(8'h00); check_pop("w1c_irq", {7'b0, irq});

        // Set beats W1C on the same edge
        csr_write(5'd2, 8'h00);
        in = 8'h04;
        step(5);
        csr_write(5'd1, 8'h04);
        expect_push(8'h04); check_pop("race_out", out);
        csr_read(5'd1, rd); expect_push(8'h04); check_pop("race_set_wins", rd);
        csr_write(5'd1, 8'h04);

        // EDGE write on the event edge: old EDGE (rising) applies to this fall
        in = 8'h00;
        step(5);
        csr_write(5'd2, 8'h04);
        expect_push(8'h00); check_pop("old_edge_out", out);
        csr_read(5'd1, rd); expect_push(8'h00); check_pop("old_edge_ip", rd);
        csr_read(5'd2, rd); expect_push(8'h04); check_pop("old_edge_rd", rd);
        csr_write(5'd2, 8'h00);

        // Unmapped addresses
        for (int a = 4; a < 32; a++) begin
            csr_read(5'(a), rd);
            expect_push(8'h00); check_pop("unmapped_rd", rd);
        end

`ifdef GPI_DEBOUNCE_BOTH_EDGES_EN
        csr_write(5'd3, 8'h80);
        csr_read(5'd3, rd); expect_push(8'h80); check_pop("both_rd", rd);
        in = 8'h80;
        step(6);
        csr_read(5'd1, rd); expect_push(8'h80); check_pop("both_rise_ip", rd);
        csr_write(5'd1, 8'h80);
        in = 8'h00;
        step(6);
        csr_read(5'd1, rd); expect_push(8'h80); check_pop("both_fall_ip", rd);
`else
        csr_write(5'd3, 8'hFF);
        csr_read(5'd3, rd); expect_push(8'h00); check_pop("rsv_rd", rd);
`endif

        // PRESCALE=10 instance
        rst10 = 1'b0;
        step(5);
        in10 = 8'h01;
        count = 0;
        while (count < 60 && out10[0] !== 1'b1) begin
            step(1);
            count++;
        end
        expect_push(8'h01); check_pop("ps10_latency_window", {7'b0, (count >= 30 && count <= 42)});
        expect_push(8'h01); check_pop("ps10_out", out10);
        expect_push(8'h01); check_pop("ps10_ip", csr_do10);
        expect_push(8'h00); check_pop("ps10_irq", {7'b0, irq10});

        // Reset mid-count: everything restarts, exact latency from release
        in10 = 8'h03;
        step(20);
        rst10 = 1'b1;
        #1;
        expect_push(8'h00); check_pop("ps10_rst_out", out10);
        expect_push(8'h00); check_pop("ps10_rst_ip", csr_do10);
        step(2);
        rst10 = 1'b0;
        count = 0;
        while (count < 60 && out10 !== 8'h03) begin
            step(1);
            count++;
        end
        expect_push(8'd40); check_pop("ps10_restart_latency", 8'(count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Input conditioning stage placed directly upstream of the GPI register block.
- Synchronises NUM_GPIOS asynchronous board inputs to clk and debounces each one with a shared tick prescaler.
- Drives the clean levels on `out`, which feeds the GPI block's `in`.
- Detects edges on the debounced levels and raises a level interrupt, configured through the same 5-bit CSR bus.

Parameters:
- BASE_ADDR, 5'b0, first CSR address; block occupies BASE_ADDR..BASE_ADDR+3.
- NUM_GPIOS, 8, number of inputs, 1..8.
- PRESCALE, 1000, clk cycles per debounce tick, >=1.
- DEBOUNCE_TICKS, 4, consecutive ticks a new level must persist before acceptance, >=1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- csr_a  input  5  CSR address
- csr_di  input  8  CSR write data
- csr_we  input  1  CSR write strobe, one write per asserted cycle
- csr_do  output  8  CSR read data, combinational
- in  input  NUM_GPIOS  raw asynchronous pins
- out  output  NUM_GPIOS  debounced levels, to GPI block
- irq  output  1  interrupt, active-high level

Behaviour:
- Reset is asynchronous, active-high. Everything clears to 0: sync flops, prescaler, per-input counters, out, IE, IP, EDGE, irq.
- Reset mid-operation discards any debounce in progress. Inputs high at reset release reach out=1 after full debounce latency. That rising event sets IP (IE=0 still masks irq).
- Synchroniser:
  - Two flops per input: s = in delayed 2 clk.
  - No reset-value glitch reaches out.
- Prescaler:
  - Free-running counter 0..PRESCALE-1 from reset.
  - tick is a 1-cycle pulse when count==PRESCALE-1; count wraps to 0.
  - PRESCALE=1 gives tick every cycle.
- Debounce, per input i, counter cnt[i] of width clog2(DEBOUNCE_TICKS) (min 1):
  - s==out[i]: cnt[i]<=0, any cycle, tick or not.
  - s!=out[i] and tick and cnt[i]==DEBOUNCE_TICKS-1: out[i]<=s, cnt[i]<=0.
  - s!=out[i] and tick otherwise: cnt[i]<=cnt[i]+1.
  - Glitch shorter than the count resets cnt; out unchanged.
  - Latency with PRESCALE=1: out changes on the (2+DEBOUNCE_TICKS)th rising edge after in changes.
- Edge detect:
  - Evaluated on the same edge that out[i] updates.
  - Rising (0->1) qualifies if EDGE[i]=0; falling (1->0) qualifies if EDGE[i]=1.
  - A qualifying change sets IP[i] on that same edge.
- CSR map, 8-bit; bits above NUM_GPIOS-1 read 0 and ignore writes:
  - BASE_ADDR+0 IE: R/W interrupt enable.
  - BASE_ADDR+1 IP: read pending; write-1-to-clear.
  - BASE_ADDR+2 EDGE: R/W edge select.
  - BASE_ADDR+3: reserved, reads 0 (unless optional feature).
- csr_do:
  - Combinational mux of the above; 8'b0 for any unmatched address.
  - Writes take effect on the clk edge with csr_we=1.
- Simultaneous W1C and new event on the same IP bit in one cycle: set wins, IP stays 1.
- IE/EDGE write and event in the same cycle: the event uses the old EDGE value.
- irq = |(IP & IE), combinational from registers, no extra latency. Clearing IE masks irq; IP is retained.

Optional Feature:
- Macro GPI_DEBOUNCE_BOTH_EDGES_EN.
- Defined:
  - BASE_ADDR+3 becomes R/W BOTH register, reset 0.
  - BOTH[i]=1 makes any change of out[i] set IP[i], ignoring EDGE[i].
- Undefined:
  - BASE_ADDR+3 reads 0, writes ignored, no BOTH storage synthesised.

Test Plan (PRESCALE=1, DEBOUNCE_TICKS=4, NUM_GPIOS=8, BASE_ADDR=0 unless stated):
- Reset with in=8'hFF; deassert rst -> out=8'h00 for 5 edges, out=8'hFF on 6th edge; IP reads 8'hFF; irq=0.
- in[3] pulses high for 3 cycles, then low -> out[3] never toggles; IP=0. Repeat with a 6-cycle pulse -> out[3] rises on 6th edge; with IE=8'h08, irq=1 the same cycle.
- Write EDGE=8'h01, IE=8'h01; drive in[0] 1 then 0 -> IP[0] set only on the falling out[0] transition; write IP=8'h01 -> IP=0, irq=0.
- Force a debounced change of in[2] on the same clk edge as write IP=8'h04 -> IP[2] reads 1.
- PRESCALE=10 -> out change occurs 30..40+2 cycles after in change; assert rst mid-count -> out=0, cnt cleared, restart full latency.
- Read addresses 4..31 -> csr_do=8'h00. With GPI_DEBOUNCE_BOTH_EDGES_EN, write addr 3=8'h80 -> both edges of in[7] set IP[7]. Without the macro, addr 3 reads 8'h00.
